// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter and r1..rN zero-fill sequencer for the register file's single write port.
// One-cycle write latency through registered rf_* outputs; req_ready stays low while a clear is starting or running.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic                      rf_reg_write,
  output logic [ADDR_W-1:0]         rf_rd_addr,
  output logic [DATA_W-1:0]         rf_write_data
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rf_reg_write_q, rf_reg_write_d;
  logic [ADDR_W-1:0]   rf_rd_addr_q, rf_rd_addr_d;
  logic [DATA_W-1:0]   rf_write_data_q, rf_write_data_d;
  logic                clear_done_q, clear_done_d;

  logic                grant_vld;
  logic [PTR_W-1:0]    grant_idx;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      cnt_q           <= '0;
      rf_reg_write_q  <= 1'b0;
      rf_rd_addr_q    <= '0;
      rf_write_data_q <= '0;
      clear_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      cnt_q           <= cnt_d;
      rf_reg_write_q  <= rf_reg_write_d;
      rf_rd_addr_q    <= rf_rd_addr_d;
      rf_write_data_q <= rf_write_data_d;
      clear_done_q    <= clear_done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    rf_reg_write_d  = 1'b0;
    rf_rd_addr_d    = rf_rd_addr_q;
    rf_write_data_d = rf_write_data_q;
    clear_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d         = CLEAR;
          rf_reg_write_d  = 1'b1;
          rf_rd_addr_d    = ADDR_W'(1);
          rf_write_data_d = '0;
          cnt_d           = ADDR_W'(2);
        end else if (grant_vld) begin
          ptr_d           = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
          rf_rd_addr_d    = req_addr[grant_idx*ADDR_W +: ADDR_W];
          rf_write_data_d = req_data[grant_idx*DATA_W +: DATA_W];
          // r0 is hardwired zero: the grant is consumed but the write is dropped.
          rf_reg_write_d  = (rf_rd_addr_d != '0);
        end
      end
      CLEAR: begin
        if (rf_rd_addr_q == LAST_ADDR) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end else begin
          rf_reg_write_d  = 1'b1;
          rf_rd_addr_d    = cnt_q;
          rf_write_data_d = '0;
          cnt_d           = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (!reset && state_q == IDLE && !clear_start && grant_vld) req_ready[grant_idx] = 1'b1;
    clear_busy    = (state_q == CLEAR);
    clear_done    = clear_done_q;
    rf_reg_write  = rf_reg_write_q;
    rf_rd_addr    = rf_rd_addr_q;
    rf_write_data = rf_write_data_q;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table for arbitration, hand sequences for clear and reset-abort.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic        rf_reg_write;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_write_data;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] rf_model [32] = '{default: '0};

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .rf_reg_write(rf_reg_write), .rf_rd_addr(rf_rd_addr), .rf_write_data(rf_write_data)
  );

  always #5 clk = ~clk;

  // Register file fed by the arbiter's write port.
  always @(posedge clk) begin
    if (rf_reg_write && rf_rd_addr != 5'd0) rf_model[rf_rd_addr] <= rf_write_data;
  end

  localparam logic [31:0] DA = 32'hAAAA_0001;
  localparam logic [31:0] DB = 32'hBBBB_0002;
  localparam logic [31:0] DC = 32'hCCCC_0003;
  localparam logic [14:0] ADDRS = {5'd7, 5'd6, 5'd5};
  localparam logic [95:0] DATAS = {DC, DB, DA};

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                              input logic [2:0] r, input logic we, input logic [4:0] ea,
                              input logic [31:0] ed);
    vec_t t;
    t.valid = v; t.addr = a; t.data = d;
    t.exp_ready = r; t.exp_we = we; t.exp_addr = ea; t.exp_data = ed;
    return t;
  endfunction

  task automatic apply(input vec_t v, input int n);
    @(negedge clk);
    req_valid = v.valid; req_addr = v.addr; req_data = v.data; clear_start = 1'b0;
    #1 chk($sformatf("v%0d_ready", n), 32'(req_ready), 32'(v.exp_ready));
    @(posedge clk); #1;
    chk($sformatf("v%0d_we", n), 32'(rf_reg_write), 32'(v.exp_we));
    chk($sformatf("v%0d_addr", n), 32'(rf_rd_addr), 32'(v.exp_addr));
    chk($sformatf("v%0d_data", n), rf_write_data, v.exp_data);
  endtask

  // Writes r1..r31 with base+i through requester 0 only.
  task automatic load_all(input logic [31:0] base);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      req_valid = 3'b001; req_addr = {10'd0, 5'(i)}; req_data = {64'd0, base + 32'(i)};
      #1 chk($sformatf("load%0d_ready", i), 32'(req_ready), 32'(3'b001));
    end
    @(negedge clk);
    req_valid = 3'b000;
    @(posedge clk); #1;
  endtask

  initial begin
    int nz;
    int done_seen;
    reset = 1'b1; req_valid = 3'b111; req_addr = ADDRS; req_data = DATAS; clear_start = 1'b0;

    // Reset held two cycles with every requester valid.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst%0d_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("rst%0d_we", c), 32'(rf_reg_write), 32'd0);
      chk($sformatf("rst%0d_addr", c), 32'(rf_rd_addr), 32'd0);
      chk($sformatf("rst%0d_data", c), rf_write_data, 32'd0);
      chk($sformatf("rst%0d_busy", c), 32'(clear_busy), 32'd0);
      chk($sformatf("rst%0d_done", c), 32'(clear_done), 32'd0);
    end
    reset = 1'b0;

    tbl[0]  = mk(3'b111, ADDRS, DATAS, 3'b001, 1'b1, 5'd5, DA);
    tbl[1]  = mk(3'b111, ADDRS, DATAS, 3'b010, 1'b1, 5'd6, DB);
    tbl[2]  = mk(3'b111, ADDRS, DATAS, 3'b100, 1'b1, 5'd7, DC);
    tbl[3]  = mk(3'b111, ADDRS, DATAS, 3'b001, 1'b1, 5'd5, DA);
    tbl[4]  = mk(3'b111, ADDRS, DATAS, 3'b010, 1'b1, 5'd6, DB);
    tbl[5]  = mk(3'b111, ADDRS, DATAS, 3'b100, 1'b1, 5'd7, DC);
    tbl[6]  = mk(3'b101, ADDRS, DATAS, 3'b001, 1'b1, 5'd5, DA);
    tbl[7]  = mk(3'b101, ADDRS, DATAS, 3'b100, 1'b1, 5'd7, DC);
    tbl[8]  = mk(3'b101, ADDRS, DATAS, 3'b001, 1'b1, 5'd5, DA);
    tbl[9]  = mk(3'b000, ADDRS, DATAS, 3'b000, 1'b0, 5'd5, DA);
    tbl[10] = mk(3'b010, {5'd7, 5'd0, 5'd5}, {DC, 32'hDEAD_BEEF, DA}, 3'b010, 1'b0, 5'd0, 32'hDEAD_BEEF);
    tbl[11] = mk(3'b111, ADDRS, DATAS, 3'b100, 1'b1, 5'd7, DC);

    for (int n = 0; n < 12; n++) apply(tbl[n], n);

    @(negedge clk);
    req_valid = 3'b000;
    @(posedge clk); #1;
    chk("rf_r5", rf_model[5], DA);
    chk("rf_r6", rf_model[6], DB);
    chk("rf_r7", rf_model[7], DC);
    chk("rf_r0", rf_model[0], 32'd0);

    // Full clear with all requesters pending; ptr is 1 afterwards from the loads.
    load_all(32'h1000_0000);
    chk("load_r31", rf_model[31], 32'h1000_001F);
    @(negedge clk);
    req_valid = 3'b111; req_addr = ADDRS; req_data = DATAS; clear_start = 1'b1;
    #1 chk("clrE_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    for (int k = 1; k < 32; k++) begin
      chk($sformatf("clr%0d_busy", k), 32'(clear_busy), 32'd1);
      chk($sformatf("clr%0d_we", k), 32'(rf_reg_write), 32'd1);
      chk($sformatf("clr%0d_addr", k), 32'(rf_rd_addr), 32'(k));
      chk($sformatf("clr%0d_data", k), rf_write_data, 32'd0);
      chk($sformatf("clr%0d_done", k), 32'(clear_done), 32'd0);
      chk($sformatf("clr%0d_ready", k), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("clr32_done", 32'(clear_done), 32'd1);
    chk("clr32_busy", 32'(clear_busy), 32'd0);
    chk("clr32_we", 32'(rf_reg_write), 32'd0);
    chk("clr32_ready", 32'(req_ready), 32'(3'b010));
    nz = 0;
    for (int r = 1; r < 32; r++) if (rf_model[r] != 32'd0) nz++;
    chk("clr_regs_nonzero", 32'(nz), 32'd0);
    @(posedge clk); #1;
    req_valid = 3'b000;
    chk("clr33_done", 32'(clear_done), 32'd0);
    chk("clr33_addr", 32'(rf_rd_addr), 32'd6);
    chk("clr33_data", rf_write_data, DB);

    // Reset during a clear, asserted while address 10 is presented.
    load_all(32'h2000_0000);
    @(negedge clk);
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      chk($sformatf("abort%0d_addr", k), 32'(rf_rd_addr), 32'(k));
      @(posedge clk); #1;
    end
    chk("abort10_addr", 32'(rf_rd_addr), 32'd10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(clear_busy), 32'd0);
    chk("abort_we", 32'(rf_reg_write), 32'd0);
    chk("abort_done", 32'(clear_done), 32'd0);
    done_seen = 0;
    for (int c = 0; c < 35; c++) begin
      @(posedge clk); #1;
      if (clear_done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    nz = 0;
    for (int r = 1; r < 10; r++) if (rf_model[r] != 32'd0) nz++;
    chk("abort_r1_9_nonzero", 32'(nz), 32'd0);
    chk("abort_r20", rf_model[20], 32'h2000_0014);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
